// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci job scheduler.
package fib_pkg;

   localparam int unsigned DefWidth = 32;
   localparam int unsigned DefIdxW  = 6;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StResp = 2'd2
   } state_e;

endpackage

// File: rtl/fib_engine.sv
// Iterative Fibonacci datapath: after k steps from a load, prev holds F(k) with
// a sticky flag that marks F(k) >= 2^WIDTH.
module fib_engine
   import fib_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_step,
   output logic [WIDTH-1:0] o_prev,
   output logic             o_prev_ovf
);

   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_curr;
   logic             r_prev_ovf;
   logic             r_curr_ovf;
   logic [WIDTH:0]   w_sum;

   assign w_sum = {1'b0, r_curr} + {1'b0, r_prev};

   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
         r_prev     <= '0;
         r_curr     <= WIDTH'(1);
         r_prev_ovf <= 1'b0;
         r_curr_ovf <= 1'b0;
      end else if (i_step) begin
         r_prev     <= r_curr;
         r_curr     <= w_sum[WIDTH-1:0];
         r_prev_ovf <= r_curr_ovf;
         // curr runs one term ahead; its flag only reaches the result one step later
         r_curr_ovf <= r_curr_ovf | r_prev_ovf | w_sum[WIDTH];
      end
   end

   assign o_prev     = r_prev;
   assign o_prev_ovf = r_prev_ovf;

endmodule

// File: rtl/fib_job_scheduler.sv
// Round-robin front end that shares one fib_engine among NUM_REQ requesters and
// returns F(n) with the owner's ID through a valid/ready response port.
module fib_job_scheduler
   import fib_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = DefWidth,
   parameter int unsigned IDX_W   = DefIdxW,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   input  logic [NUM_REQ*IDX_W-1:0] i_req_index,
   output logic [NUM_REQ-1:0]       o_req_ready,
   output logic                     o_resp_valid,
   input  logic                     i_resp_ready,
   output logic [ID_W-1:0]          o_resp_id,
   output logic [WIDTH-1:0]         o_resp_data,
   output logic                     o_resp_overflow,
   output logic                     o_busy
);

   state_e           r_state;
   state_e           w_state_next;
   logic [IDX_W-1:0] r_count;
   logic [IDX_W-1:0] w_count_next;
   logic [ID_W-1:0]  r_id;
   logic [ID_W-1:0]  r_rr_ptr;

   logic             w_found;
   logic [ID_W-1:0]  w_grant_id;
   logic [IDX_W-1:0] w_grant_index;
   logic             w_accept;
   logic             w_load;
   logic             w_step;
   logic [WIDTH-1:0] w_prev;
   logic             w_prev_ovf;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int unsigned     off);
      int unsigned s;
      s = int'(base) + off;
      return ID_W'(s % NUM_REQ);
   endfunction

   // Search starts at rr_ptr so the last winner has lowest priority next time.
   always_comb begin
      w_found    = 1'b0;
      w_grant_id = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!w_found && i_req_valid[wrap_add(r_rr_ptr, k)]) begin
            w_found    = 1'b1;
            w_grant_id = wrap_add(r_rr_ptr, k);
         end
      end
   end

   assign w_grant_index = i_req_index[int'(w_grant_id)*IDX_W +: IDX_W];
   assign w_accept      = (r_state == StIdle) && w_found && !i_rst;

   always_comb begin
      o_req_ready = '0;
      if (w_accept) begin
         o_req_ready[w_grant_id] = 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_load       = 1'b0;
      w_step       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_load       = 1'b1;
               w_count_next = w_grant_index;
               w_state_next = (w_grant_index == '0) ? StResp : StRun;
            end
         end
         StRun: begin
            w_step       = 1'b1;
            w_count_next = r_count - IDX_W'(1);
            if (r_count == IDX_W'(1)) begin
               w_state_next = StResp;
            end
         end
         StResp: begin
            if (i_resp_ready) begin
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_count  <= '0;
         r_id     <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_accept) begin
            r_id     <= w_grant_id;
            r_rr_ptr <= wrap_add(w_grant_id, 1);
         end
      end
   end

   fib_engine #(
      .WIDTH (WIDTH)
   ) u_engine (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_step     (w_step),
      .o_prev     (w_prev),
      .o_prev_ovf (w_prev_ovf)
   );

   // Engine is frozen in RESP, so its outputs double as the response registers.
   assign o_resp_valid    = (r_state == StResp);
   assign o_resp_id       = r_id;
   assign o_resp_data     = w_prev;
   assign o_resp_overflow = w_prev_ovf;
   assign o_busy          = (r_state != StIdle);

endmodule

// File: tb/tb_fib_job_scheduler.sv
// Directed bench for fib_job_scheduler: vector table of single jobs plus
// sequences for arbitration order, response back-pressure and mid-job reset.
module tb_fib_job_scheduler;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned IDX_W   = 6;
   localparam int unsigned ID_W    = 2;

   logic                     i_clk = 1'b0;
   logic                     i_rst = 1'b1;
   logic [NUM_REQ-1:0]       i_req_valid = '0;
   logic [NUM_REQ*IDX_W-1:0] i_req_index = '0;
   logic [NUM_REQ-1:0]       o_req_ready;
   logic                     o_resp_valid;
   logic                     i_resp_ready = 1'b0;
   logic [ID_W-1:0]          o_resp_id;
   logic [WIDTH-1:0]         o_resp_data;
   logic                     o_resp_overflow;
   logic                     o_busy;

   int checks   = 0;
   int failures = 0;

   fib_job_scheduler #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .IDX_W   (IDX_W),
      .ID_W    (ID_W)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_req_valid     (i_req_valid),
      .i_req_index     (i_req_index),
      .o_req_ready     (o_req_ready),
      .o_resp_valid    (o_resp_valid),
      .i_resp_ready    (i_resp_ready),
      .o_resp_id       (o_resp_id),
      .o_resp_data     (o_resp_data),
      .o_resp_overflow (o_resp_overflow),
      .o_busy          (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int          req;
      int          n;
      logic [31:0] data;
      logic        ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Caller is at a negedge with the DUT idle.
   task automatic run_job(input int r, input int n, input logic [31:0] exp_d,
                          input logic exp_o, input string name);
      int lat;
      logic [NUM_REQ-1:0] onehot;
      logic [IDX_W-1:0] nv;
      nv = IDX_W'(n);
      onehot = '0;
      onehot[r] = 1'b1;
      i_req_index[r*IDX_W +: IDX_W] = nv;
      i_req_valid = onehot;
      #1;
      check({name, ".ready"}, 64'(o_req_ready), 64'(onehot));
      @(posedge i_clk);
      @(negedge i_clk);
      i_req_valid = '0;
      lat = 1;
      #1;
      while (!o_resp_valid && lat < 100) begin
         @(negedge i_clk);
         #1;
         lat++;
      end
      check({name, ".latency"}, 64'(lat), 64'(n + 1));
      check({name, ".data"}, 64'(o_resp_data), 64'(exp_d));
      check({name, ".id"}, 64'(o_resp_id), 64'(r));
      check({name, ".ovf"}, 64'(o_resp_overflow), 64'(exp_o));
      i_resp_ready = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_resp_ready = 1'b0;
      #1;
      check({name, ".idle_after"}, 64'(o_busy), 64'(0));
   endtask

   initial begin
      logic [NUM_REQ-1:0] mask;
      int cnt;
      int gi;

      vecs[0] = '{req: 0, n: 0,  data: 32'd0,          ovf: 1'b0};
      vecs[1] = '{req: 2, n: 10, data: 32'd55,         ovf: 1'b0};
      vecs[2] = '{req: 1, n: 1,  data: 32'd1,          ovf: 1'b0};
      vecs[3] = '{req: 3, n: 2,  data: 32'd1,          ovf: 1'b0};
      vecs[4] = '{req: 0, n: 32, data: 32'd2178309,    ovf: 1'b0};
      vecs[5] = '{req: 1, n: 47, data: 32'd2971215073, ovf: 1'b0};
      vecs[6] = '{req: 2, n: 48, data: 32'd512559680,  ovf: 1'b1};
      vecs[7] = '{req: 3, n: 63, data: 32'd3350226146, ovf: 1'b1};

      // Reset state, and no accept while rst is high even with requests pending.
      @(negedge i_clk);
      i_req_valid = 4'hF;
      #1;
      check("rst.ready", 64'(o_req_ready), 64'(0));
      check("rst.resp_valid", 64'(o_resp_valid), 64'(0));
      check("rst.data", 64'(o_resp_data), 64'(0));
      check("rst.id", 64'(o_resp_id), 64'(0));
      check("rst.ovf", 64'(o_resp_overflow), 64'(0));
      @(negedge i_clk);
      i_rst = 1'b0;
      i_req_valid = '0;
      #1;
      check("rst.busy", 64'(o_busy), 64'(0));

      for (int i = 0; i < 8; i++) begin
         run_job(vecs[i].req, vecs[i].n, vecs[i].data, vecs[i].ovf, $sformatf("vec%0d", i));
      end

      // Round-robin: reset pointer, then two rounds with everyone requesting.
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      i_resp_ready = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) i_req_index[r*IDX_W +: IDX_W] = 6'd1;
      mask = 4'hF;
      i_req_valid = mask;
      for (int g = 0; g < 8; g++) begin
         cnt = 0;
         #1;
         while (o_req_ready == '0 && cnt < 50) begin
            @(negedge i_clk);
            #1;
            cnt++;
         end
         check($sformatf("rr.wait%0d", g), 64'(cnt < 50), 64'(1));
         gi = 0;
         for (int r = 0; r < NUM_REQ; r++) if (o_req_ready[r]) gi = r;
         check($sformatf("rr.grant%0d", g), 64'(o_req_ready), 64'(1 << (g % 4)));
         @(posedge i_clk);
         @(negedge i_clk);
         mask[gi] = 1'b0;
         if (mask == '0 && g == 3) mask = 4'hF;
         i_req_valid = mask;
      end
      i_req_valid = '0;
      cnt = 0;
      #1;
      while (o_busy && cnt < 50) begin
         @(negedge i_clk);
         #1;
         cnt++;
      end
      i_resp_ready = 1'b0;

      // Back-pressure: hold resp_ready low for 5 cycles in RESP.
      i_req_index[1*IDX_W +: IDX_W] = 6'd3;
      i_req_valid = 4'b0010;
      @(posedge i_clk);
      @(negedge i_clk);
      i_req_valid = 4'hF;
      cnt = 0;
      #1;
      while (!o_resp_valid && cnt < 20) begin
         @(negedge i_clk);
         #1;
         cnt++;
      end
      check("stall.reach_resp", 64'(o_resp_valid), 64'(1));
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall.data%0d", c), 64'(o_resp_data), 64'(2));
         check($sformatf("stall.id%0d", c), 64'(o_resp_id), 64'(1));
         check($sformatf("stall.valid%0d", c), 64'(o_resp_valid), 64'(1));
         check($sformatf("stall.ready%0d", c), 64'(o_req_ready), 64'(0));
         @(negedge i_clk);
         #1;
      end
      i_resp_ready = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_resp_ready = 1'b0;
      #1;
      check("stall.idle_after", 64'(o_busy), 64'(0));
      // rr_ptr is 2 after granting requester 1.
      check("stall.next_grant", 64'(o_req_ready), 64'(4'b0100));
      i_req_valid = '0;

      // Reset in the middle of a long job.
      @(negedge i_clk);
      i_req_index[3*IDX_W +: IDX_W] = 6'd20;
      i_req_valid = 4'b1000;
      @(posedge i_clk);
      @(negedge i_clk);
      i_req_valid = '0;
      repeat (5) @(negedge i_clk);
      #1;
      check("midrst.running", 64'(o_busy), 64'(1));
      i_rst = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check("midrst.resp_valid", 64'(o_resp_valid), 64'(0));
      check("midrst.busy", 64'(o_busy), 64'(0));
      check("midrst.data", 64'(o_resp_data), 64'(0));
      run_job(0, 5, 32'd5, 1'b0, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/fib_job_scheduler.md
# fib_job_scheduler

Shares one iterative Fibonacci engine between `NUM_REQ` requesters. Each requester submits an index `n` through a valid/ready handshake. A round-robin arbiter grants one job at a time. The block then sequences the engine for `n` steps and returns F(n) with the requester ID and an overflow flag through a valid/ready response port. It sits between client blocks and the shared Fibonacci datapath.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2)
- `WIDTH`, 32: result width
- `IDX_W`, 6: width of the requested index
- `ID_W`, $clog2(NUM_REQ): width of response ID

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous and active-high
- `req_valid`  in  NUM_REQ  per-requester job valid
- `req_index`  in  NUM_REQ*IDX_W  per-requester index n; slice i belongs to requester i
- `req_ready`  out  NUM_REQ  one-hot grant/accept
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  consumer accepts result
- `resp_id`  out  ID_W  requester that owns the result
- `resp_data`  out  WIDTH  F(n) mod 2^WIDTH
- `resp_overflow`  out  1  F(n) ≥ 2^WIDTH
- `busy`  out  1  high in every state except IDLE

## Operation
- F(0)=0 and F(1)=1.
- Engine registers:
  - load: prev=0, curr=1.
  - step: prev<=curr, curr<=curr+prev, both truncated to WIDTH.
  - After k steps, prev=F(k).
- Overflow tracking:
  - Flag `curr_ovf` is set sticky on carry-out of curr+prev, or when prev is already flagged.
  - On each step, `prev_ovf<=curr_ovf`.
  - The result overflow is `prev_ovf`. It is not set by curr running ahead to F(n+1).
- FSM states: IDLE, RUN, RESP.
  - IDLE: the arbiter picks the first asserted `req_valid` starting at pointer `rr_ptr` and wrapping modulo NUM_REQ. The winner's `req_ready` bit is high in the same cycle (combinational). All other bits stay 0.
  - On accept, the block latches id and n, loads the engine, and sets `count=n`. It then moves to RESP if n==0, else to RUN. It sets `rr_ptr=(id+1) mod NUM_REQ`.
  - RUN: one engine step per cycle with count--. When count reaches 1, it takes the final step and moves to RESP.
  - RESP: `resp_valid=1`. `resp_data`, `resp_id` and `resp_overflow` are stable until `resp_ready`. On the handshake cycle it returns to IDLE.
- `req_ready` is 0 outside IDLE. A requester whose valid is not granted keeps waiting.
- The block never drops or reorders an accepted job.
- Reset, including mid-RUN or mid-RESP, abandons the job. All outputs below return to reset values.
- Reset values:
  - state=IDLE
  - `resp_valid=0`, `resp_data=0`, `resp_id=0`, `resp_overflow=0`
  - `busy=0`, `rr_ptr=0`
  - engine prev=0, curr=1, flags cleared
  - `req_ready=0` while `rst` is high

## Timing
- Accept at cycle t, index n: `resp_valid` rises at cycle t+1+n.
  - n=0: t+1.
  - n=63: t+64.
- Response handshake at cycle r: IDLE at r+1. The earliest next accept is r+1.
- Minimum job period is n+2 cycles.
- `req_valid` dropping while not granted is legal. The request is simply not taken.
- If `rst` is asserted in the same cycle as a handshake, reset wins and nothing is accepted.

## Structure
- Shared package `fib_pkg`:
  - FSM state typedef (IDLE/RUN/RESP)
  - default WIDTH/IDX_W constants
- Sub-module `fib_engine`:
  - ports: clk, rst, load, step, prev, prev_ovf
  - holds the prev/curr registers and overflow flags
- The scheduler owns the arbiter, count, FSM and response registers.

## Test plan
- Requester 0 sends n=0 → `resp_valid` at t+1, data=0, id=0, overflow=0.
- Requester 2 sends n=10 → data=55 at t+11, id=2.
- n=47 → data=2971215073, overflow=0. n=48 → data=512559680, overflow=1.
- All 4 requesters valid, with ready-side always accepting → grants 0,1,2,3, then 0 again. Requester 3 re-asserting after its grant is served after 0,1,2.
- `resp_ready` held low 5 cycles in RESP → outputs stable, `req_ready` all 0, then IDLE one cycle after the handshake.
- `rst` pulse mid-RUN for n=20 → next cycle `resp_valid=0` and `busy=0`. A new n=5 job returns 5 with correct latency.
